// File: rtl/spi_boot_loader_if.sv
// Pin and port bundle of the boot loader: SPI EEPROM pins plus the SRAM
// write port and the two status flags. The loader drives it as master.
interface spi_boot_loader_if;
  logic        i_spiMISO;
  logic        o_spiMOSI;
  logic        o_spiCLK;
  logic        o_spiCSn;
  logic [15:0] o_memAddr;
  logic [15:0] o_memDataOut;
  logic        o_memWr;
  logic        o_memEn;
  logic        o_isBusy;
  logic        o_isBooted;

  modport master (
    input  i_spiMISO,
    output o_spiMOSI, o_spiCLK, o_spiCSn,
    output o_memAddr, o_memDataOut, o_memWr, o_memEn,
    output o_isBusy, o_isBooted
  );

  modport slave (
    output i_spiMISO,
    input  o_spiMOSI, o_spiCLK, o_spiCSn,
    input  o_memAddr, o_memDataOut, o_memWr, o_memEn,
    input  o_isBusy, o_isBooted
  );
endinterface

// File: rtl/spi_boot_loader.sv
// Boot-time copier: one SPI READ (0x03) at EEPROM address 0, then a
// continuous read of NUM_WORDS big-endian 16-bit words into SRAM 0..N-1.
// All outputs are registered; SCLK is mode 0 with CLK_DIV cycles per phase.
module spi_boot_loader #(
  parameter int CLK_DIV   = 2,
  parameter int NUM_WORDS = 32768
) (
  input logic               i_clk,
  input logic               i_rst,
  spi_boot_loader_if.master bus
);
  localparam int               DIV_W         = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0]      LAST_WORD     = 16'(NUM_WORDS - 1);
  localparam logic [23:0]      CMD_FRAME     = {8'h03, 16'h0000};
  localparam logic [4:0]       CMD_LAST_BIT  = 5'd23;
  localparam logic [4:0]       DATA_LAST_BIT = 5'd15;

  typedef enum logic [2:0] {START, CMD, DATA, WRITE, DONE} loaderState_t;

  loaderState_t     state, stateNext;
  logic [DIV_W-1:0] divCnt, divCntNext;
  logic [4:0]       bitCnt, bitCntNext;
  logic [15:0]      wordIdx, wordIdxNext;
  logic [15:0]      dataShift, dataShiftNext;
  logic             spiClk, spiClkNext;
  logic             spiMosi, spiMosiNext;
  logic             spiCsn, spiCsnNext;
  logic             memEn, memEnNext;
  logic             memWr, memWrNext;
  logic [15:0]      memAddr, memAddrNext;
  logic [15:0]      memData, memDataNext;
  logic             isBusy, isBusyNext;
  logic             isBooted, isBootedNext;

  // State and output registers; everything returns to its idle value on reset.
  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (i_rst) begin
      state     <= START;
      divCnt    <= '0;
      bitCnt    <= '0;
      wordIdx   <= '0;
      dataShift <= '0;
      spiClk    <= 1'b0;
      spiMosi   <= 1'b0;
      spiCsn    <= 1'b1;
      memEn     <= 1'b0;
      memWr     <= 1'b0;
      memAddr   <= '0;
      memData   <= '0;
      isBusy    <= 1'b0;
      isBooted  <= 1'b0;
    end else begin
      state     <= stateNext;
      divCnt    <= divCntNext;
      bitCnt    <= bitCntNext;
      wordIdx   <= wordIdxNext;
      dataShift <= dataShiftNext;
      spiClk    <= spiClkNext;
      spiMosi   <= spiMosiNext;
      spiCsn    <= spiCsnNext;
      memEn     <= memEnNext;
      memWr     <= memWrNext;
      memAddr   <= memAddrNext;
      memData   <= memDataNext;
      isBusy    <= isBusyNext;
      isBooted  <= isBootedNext;
    end
  end

  // Next-state and next-output logic: SPI bit timing, word assembly, write strobe.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch; memory strobes default to inactive.
    stateNext     = state;
    divCntNext    = divCnt;
    bitCntNext    = bitCnt;
    wordIdxNext   = wordIdx;
    dataShiftNext = dataShift;
    spiClkNext    = spiClk;
    spiMosiNext   = spiMosi;
    spiCsnNext    = spiCsn;
    memEnNext     = 1'b0;
    memWrNext     = 1'b0;
    memAddrNext   = '0;
    memDataNext   = '0;
    isBusyNext    = isBusy;
    isBootedNext  = isBooted;

    case (state)
      START: begin
        stateNext   = CMD;
        spiCsnNext  = 1'b0;
        isBusyNext  = 1'b1;
        spiClkNext  = 1'b0;
        spiMosiNext = CMD_FRAME[23];
        divCntNext  = '0;
        bitCntNext  = '0;
      end

      CMD, DATA: begin
        if (divCnt != DIV_LAST) begin
          divCntNext = divCnt + 1'b1;
        end else begin
          divCntNext = '0;
          if (!spiClk) begin
            // Rising SCLK edge: EEPROM data is valid, capture it.
            spiClkNext = 1'b1;
            if (state == DATA) dataShiftNext = {dataShift[14:0], bus.i_spiMISO};
          end else begin
            // Falling SCLK edge: end of a bit, MOSI may move on.
            spiClkNext = 1'b0;
            if (state == CMD) begin
              if (bitCnt == CMD_LAST_BIT) begin
                stateNext   = DATA;
                bitCntNext  = '0;
                spiMosiNext = 1'b0;
              end else begin
                bitCntNext  = bitCnt + 5'd1;
                spiMosiNext = CMD_FRAME[5'd22 - bitCnt];
              end
            end else if (bitCnt == DATA_LAST_BIT) begin
              stateNext   = WRITE;
              bitCntNext  = '0;
              memEnNext   = 1'b1;
              memWrNext   = 1'b1;
              memAddrNext = wordIdx;
              memDataNext = dataShift;
            end else begin
              bitCntNext = bitCnt + 5'd1;
            end
          end
        end
      end

      WRITE: begin
        // CSn stays low: the EEPROM keeps streaming the next word.
        wordIdxNext = wordIdx + 16'd1;
        if (wordIdx == LAST_WORD) begin
          stateNext    = DONE;
          spiCsnNext   = 1'b1;
          isBusyNext   = 1'b0;
          isBootedNext = 1'b1;
        end else begin
          stateNext = DATA;
        end
      end

      DONE: begin
        stateNext = DONE;
      end

      default: stateNext = START;
    endcase
  end

  assign bus.o_spiMOSI    = spiMosi;
  assign bus.o_spiCLK     = spiClk;
  assign bus.o_spiCSn     = spiCsn;
  assign bus.o_memAddr    = memAddr;
  assign bus.o_memDataOut = memData;
  assign bus.o_memWr      = memWr;
  assign bus.o_memEn      = memEn;
  assign bus.o_isBusy     = isBusy;
  assign bus.o_isBooted   = isBooted;
endmodule

// File: tb/tb_spi_boot_loader.sv
// Directed bench for spi_boot_loader: dutA (CLK_DIV=2, 4 words) covers the
// command frame, copy timing, completion, idle after DONE and mid-transfer
// reset; dutB (CLK_DIV=1, 1 word) covers the fastest SCLK setting.
module tb_spi_boot_loader;
  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  spi_boot_loader_if busA ();
  spi_boot_loader_if busB ();

  spi_boot_loader #(.CLK_DIV(2), .NUM_WORDS(4)) dutA (.i_clk(clk), .i_rst(rstA), .bus(busA));
  spi_boot_loader #(.CLK_DIV(1), .NUM_WORDS(1)) dutB (.i_clk(clk), .i_rst(rstB), .bus(busB));

  always #5 clk = ~clk;

  // Cycle counter; a value sampled at a negedge names the cycle just begun.
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- EEPROM models ----------------
  logic [7:0]  romA [8] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'h80, 8'h01};
  logic [7:0]  romB [2] = '{8'h5A, 8'hA5};
  int          bitNumA = 0;
  int          bitNumB = 0;
  logic        prevClkA = 1'b0;
  logic        prevClkB = 1'b0;
  logic [23:0] cmdShA = '0;
  logic [23:0] cmdFrameA = '0;
  int          cmdFramesA = 0;

  // Counts completed SCLK rising edges while selected; captures the command.
  always @(posedge clk) begin
    prevClkA <= busA.o_spiCLK;
    if (busA.o_spiCSn) begin
      bitNumA <= 0;
    end else if (busA.o_spiCLK && !prevClkA) begin
      bitNumA <= bitNumA + 1;
      if (bitNumA < 24) cmdShA <= {cmdShA[22:0], busA.o_spiMOSI};
      if (bitNumA == 23) begin
        cmdFrameA  <= {cmdShA[22:0], busA.o_spiMOSI};
        cmdFramesA <= cmdFramesA + 1;
      end
    end
  end

  always @(posedge clk) begin
    prevClkB <= busB.o_spiCLK;
    if (busB.o_spiCSn) bitNumB <= 0;
    else if (busB.o_spiCLK && !prevClkB) bitNumB <= bitNumB + 1;
  end

  // Byte stream starts after the 24 command bits, MSB first.
  assign busA.i_spiMISO = (bitNumA >= 24 && bitNumA < 88) ?
                          romA[(bitNumA - 24) / 8][7 - ((bitNumA - 24) % 8)] : 1'b0;
  assign busB.i_spiMISO = (bitNumB >= 24 && bitNumB < 40) ?
                          romB[(bitNumB - 24) / 8][7 - ((bitNumB - 24) % 8)] : 1'b0;

  // ---------------- Monitors (negedge) ----------------
  int          wrCntA = 0;
  int          wrCycA [32];
  logic [15:0] wrAddrA [32];
  logic [15:0] wrDataA [32];
  int          csnFallCycA = 0;
  int          bootCycA = 0;
  int          sclkEdgesA = 0;
  int          strobeErrA = 0;
  int          edgeIdxA = 0;
  int          edgeCycA [3];
  logic        pCsnA = 1'b1;
  logic        pClkA = 1'b0;
  logic        pBootA = 1'b0;

  always @(negedge clk) begin
    if (busA.o_memEn === 1'b1 && wrCntA < 32) begin
      wrCycA[wrCntA]  <= cyc;
      wrAddrA[wrCntA] <= busA.o_memAddr;
      wrDataA[wrCntA] <= busA.o_memDataOut;
      wrCntA          <= wrCntA + 1;
    end
    if ((busA.o_memWr && !busA.o_memEn) ||
        (!busA.o_memEn && {busA.o_memAddr, busA.o_memDataOut} != 32'd0))
      strobeErrA <= strobeErrA + 1;
    if (pCsnA && !busA.o_spiCSn) begin
      csnFallCycA <= cyc;
      edgeIdxA    <= 0;
    end else if (busA.o_spiCLK != pClkA) begin
      if (edgeIdxA < 3) edgeCycA[edgeIdxA] <= cyc;
      edgeIdxA <= edgeIdxA + 1;
    end
    if (busA.o_spiCLK != pClkA) sclkEdgesA <= sclkEdgesA + 1;
    if (!pBootA && busA.o_isBooted) bootCycA <= cyc;
    pCsnA  <= busA.o_spiCSn;
    pClkA  <= busA.o_spiCLK;
    pBootA <= busA.o_isBooted;
  end

  int          wrCntB = 0;
  int          wrCycB = 0;
  logic [15:0] wrAddrB = '0;
  logic [15:0] wrDataB = '0;
  int          csnFallCycB = 0;
  int          bootCycB = 0;
  int          sclkEdgesB = 0;
  int          edgeCycB [3];
  logic        pCsnB = 1'b1;
  logic        pClkB = 1'b0;
  logic        pBootB = 1'b0;

  always @(negedge clk) begin
    if (busB.o_memEn === 1'b1) begin
      wrCycB  <= cyc;
      wrAddrB <= busB.o_memAddr;
      wrDataB <= busB.o_memDataOut;
      wrCntB  <= wrCntB + 1;
    end
    if (pCsnB && !busB.o_spiCSn) csnFallCycB <= cyc;
    if (busB.o_spiCLK != pClkB) begin
      if (sclkEdgesB < 3) edgeCycB[sclkEdgesB] <= cyc;
      sclkEdgesB <= sclkEdgesB + 1;
    end
    if (!pBootB && busB.o_isBooted) bootCycB <= cyc;
    pCsnB  <= busB.o_spiCSn;
    pClkB  <= busB.o_spiCLK;
    pBootB <= busB.o_isBooted;
  end

  // ---------------- Helpers ----------------
  localparam logic [38:0] RESET_VEC = {1'b1, 38'd0};
  localparam logic [15:0] EXP_A [4] = '{16'h1234, 16'hABCD, 16'h00FF, 16'h8001};

  function automatic logic [38:0] vecA();
    return {busA.o_spiCSn, busA.o_spiCLK, busA.o_spiMOSI, busA.o_memEn, busA.o_memWr,
            busA.o_isBusy, busA.o_isBooted, busA.o_memAddr, busA.o_memDataOut};
  endfunction

  function automatic logic [38:0] vecB();
    return {busB.o_spiCSn, busB.o_spiCLK, busB.o_spiMOSI, busB.o_memEn, busB.o_memWr,
            busB.o_isBusy, busB.o_isBooted, busB.o_memAddr, busB.o_memDataOut};
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- Directed sequence ----------------
  int base;
  initial begin
    rstA = 1'b1;
    rstB = 1'b1;
    tick(1);

    // Reset held: outputs sit at reset values every cycle.
    for (int i = 0; i < 10; i++) begin
      check("reset_hold_a", vecA(), RESET_VEC);
      tick(1);
    end
    check("reset_hold_b", vecB(), RESET_VEC);

    // Release: START for one cycle, then CSn low with MOSI = bit 23 (0).
    rstA = 1'b0;
    check("start_cycle_a", vecA(), RESET_VEC);
    tick(1);
    check("cmd_entry", {busA.o_spiCSn, busA.o_isBusy, busA.o_spiMOSI, busA.o_spiCLK}, 4'b0100);

    for (int i = 0; i < 2000 && !busA.o_isBooted; i++) tick(1);
    check("a_booted", busA.o_isBooted, 1'b1);
    tick(1);

    check("cmd_frame", cmdFrameA, 24'h030000);
    check("cmd_frames", cmdFramesA, 1);
    check("sclk_first_low", edgeCycA[0] - csnFallCycA, 2);
    check("sclk_high_len", edgeCycA[1] - edgeCycA[0], 2);
    check("sclk_period", edgeCycA[2] - edgeCycA[0], 4);
    check("sclk_edges", sclkEdgesA, 176);
    check("write_count", wrCntA, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wr%0d_addr", k), wrAddrA[k], k);
      check($sformatf("wr%0d_data", k), wrDataA[k], EXP_A[k]);
      check($sformatf("wr%0d_cycle", k), wrCycA[k] - csnFallCycA, 160 + 65 * k);
    end
    check("boot_cycle", bootCycA - csnFallCycA, 356);
    check("done_pins", {busA.o_spiCSn, busA.o_isBusy, busA.o_isBooted}, 3'b101);

    // DONE is quiet: no SCLK edges, no memory access.
    base = sclkEdgesA;
    tick(1000);
    check("idle_sclk", sclkEdgesA, base);
    check("idle_writes", wrCntA, 4);
    check("idle_pins", {busA.o_spiCSn, busA.o_isBusy, busA.o_isBooted, busA.o_memEn}, 4'b1010);
    check("strobe_rules", strobeErrA, 0);

    // Restart, then reset again in the middle of word 2.
    rstA = 1'b1;
    tick(1);
    rstA = 1'b0;
    base = wrCntA;
    for (int i = 0; i < 500 && wrCntA < base + 2; i++) tick(1);
    check("midrst_reach_word2", wrCntA, base + 2);
    tick(20);
    rstA = 1'b1;
    tick(1);
    check("midrst_outputs", vecA(), RESET_VEC);
    check("midrst_cmd_frames", cmdFramesA, 2);
    rstA = 1'b0;
    tick(1);
    base = wrCntA;
    for (int i = 0; i < 2000 && !busA.o_isBooted; i++) tick(1);
    check("rerun_booted", busA.o_isBooted, 1'b1);
    tick(1);
    check("rerun_cmd_frames", cmdFramesA, 3);
    check("rerun_cmd_frame", cmdFrameA, 24'h030000);
    check("rerun_write_count", wrCntA, base + 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rerun%0d_addr", k), wrAddrA[base + k], k);
      check($sformatf("rerun%0d_data", k), wrDataA[base + k], EXP_A[k]);
      check($sformatf("rerun%0d_cycle", k), wrCycA[base + k] - csnFallCycA, 160 + 65 * k);
    end
    check("rerun_boot_cycle", bootCycA - csnFallCycA, 356);
    check("rerun_strobe_rules", strobeErrA, 0);

    // CLK_DIV=1, one word: SCLK toggles every cycle, single write at N+80.
    rstB = 1'b0;
    for (int i = 0; i < 500 && !busB.o_isBooted; i++) tick(1);
    check("b_booted", busB.o_isBooted, 1'b1);
    tick(1);
    check("b_write_count", wrCntB, 1);
    check("b_addr", wrAddrB, 16'h0000);
    check("b_data", wrDataB, 16'h5AA5);
    check("b_write_cycle", wrCycB - csnFallCycB, 80);
    check("b_boot_cycle", bootCycB - csnFallCycB, 81);
    check("b_sclk_first", edgeCycB[0] - csnFallCycB, 1);
    check("b_sclk_toggle", {edgeCycB[1] - edgeCycB[0], edgeCycB[2] - edgeCycB[1]}, {32'd1, 32'd1});
    check("b_sclk_edges", sclkEdgesB, 80);
    check("b_done_pins", {busB.o_spiCSn, busB.o_isBusy, busB.o_memEn}, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_boot_loader.md
Name: spi_boot_loader

Overview:
Boot-time copier that sits between the SPI storage EEPROM pins and the runtime SRAM port. Out of reset it issues one EEPROM READ (0x03) at byte address 0x0000 and streams NUM_WORDS 16-bit words into SRAM addresses 0..NUM_WORDS-1. When the last word is written it raises o_isBooted, which the processor state machine consumes as its "booted" indication. It drives the o_spi* pins and, while busy, owns the memory port.

Parameters:
CLK_DIV, 2, i_clk cycles per SPI clock half-period (>=1); SCLK = f(i_clk)/(2*CLK_DIV)
NUM_WORDS, 32768, words copied (1..32768); EEPROM byte span = 2*NUM_WORDS

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_spiMISO  input  1  EEPROM serial data out, already synchronized
o_spiMOSI  output  1  serial data to EEPROM
o_spiCLK  output  1  SPI clock, mode 0 (idle low)
o_spiCSn  output  1  EEPROM chip select, active-low
o_memAddr  output  16  SRAM word address
o_memDataOut  output  16  SRAM write data
o_memWr  output  1  SRAM write strobe (with o_memEn)
o_memEn  output  1  SRAM access enable
o_isBusy  output  1  high while copying; loader owns memory port
o_isBooted  output  1  high once all words written; sticky until reset

Behaviour:
- Reset (any cycle, including mid-transfer): next state START; o_spiCSn=1, o_spiCLK=0, o_spiMOSI=0, o_memEn=0, o_memWr=0, o_memAddr=0, o_memDataOut=0, o_isBusy=0, o_isBooted=0; divider, bit and word counters cleared. An aborted transfer is simply restarted from word 0 after reset releases; no partial state is kept.
- States: START -> CMD -> DATA -> WRITE -> (DATA | DONE).
- START: lasts 1 cycle. Transitions to CMD with o_spiCSn=0, o_isBusy=1 and o_spiMOSI = bit 23 of the 24-bit frame {8'h03, 16'h0000}.
- SPI bit timing, for each bit in CMD and DATA:
  - o_spiCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - i_spiMISO is sampled on the i_clk edge that drives o_spiCLK 0->1.
  - o_spiMOSI changes only on the edge that drives o_spiCLK 1->0, or on state entry. Bits are sent MSB first.
- CMD: 24 bits. After the 24th high phase, go to DATA with o_spiCLK=0. o_spiMOSI=0 for the rest of the transaction.
- DATA: 16 bits shifted into a data register MSB-first. The first EEPROM byte is bits [15:8] and the second is bits [7:0]. After the 16th high phase, go to WRITE.
- WRITE: exactly 1 cycle.
  - o_memEn=1, o_memWr=1, o_memAddr=word index, o_memDataOut=assembled word.
  - o_spiCLK held low and o_spiCSn stays low (continuous read; no new command per word).
  - Word index increments after the cycle.
  - If index was NUM_WORDS-1, go to DONE; otherwise go to DATA.
- DONE: o_spiCSn=1, o_isBusy=0, o_isBooted=1, memory outputs 0. Stays here until i_rst.
- Timing (cycle N = first cycle o_spiCSn=0):
  - Word 0 WRITE cycle = N + 80*CLK_DIV.
  - Word k WRITE cycle = word 0 WRITE + k*(32*CLK_DIV+1).
  - o_isBooted rises the cycle after the last WRITE, the same cycle o_spiCSn returns high.
- o_memWr is never high without o_memEn. In all non-WRITE states both are 0 and o_memAddr/o_memDataOut are 0.
- Widths: word counter is 16 bits, compared against NUM_WORDS-1, so there is no wrap at 32768. Bit counter is 5 bits. Divider counter is clog2(CLK_DIV)+1 bits.

Test Plan:
- Command frame: CLK_DIV=2, NUM_WORDS=4, MISO model idle. Capture MOSI on SCLK rising edges -> bits 0000_0011 then sixteen 0s. CSn low from cycle 1 after reset release. SCLK period exactly 4 cycles, high 2 cycles.
- Data copy: EEPROM model returns bytes 12 34 AB CD 00 FF 80 01 -> exactly four single-cycle writes: addr0=0x1234, addr1=0xABCD, addr2=0x00FF, addr3=0x8001. Write cycles at N+160, N+225, N+290, N+355.
- Completion: same run -> CSn high, o_isBusy=0 and o_isBooted=1 in cycle N+356. No further SCLK edges, memEn or memWr over the next 1000 cycles.
- Mid-transfer reset: assert i_rst during word 2 DATA -> next cycle CSn=1, SCLK=0, memEn=0, isBooted=0. After release, the full command is reissued and addr0..3 are rewritten with the same values.
- CLK_DIV=1, NUM_WORDS=1, bytes 5A A5 -> SCLK toggles every cycle. Single write addr0=0x5AA5 at N+80, then DONE.
- Reset held for 10 cycles -> all outputs hold their reset values throughout; START occurs exactly 1 cycle after release.
